instr_fetch: RTL and testbench

- Fetch stage directly upstream of the instruction memory read port.
- Generates the byte address presented to the memory each cycle, absorbs the memory's one-cycle registered read latency, and tags each returned word with its PC.
- Buffers instructions in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports redirects from execute (branch/jump) that flush all fetched and in-flight work.

---
 rtl/pako_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/instr_fetch.sv | 145 ++++++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pako_pkg.sv
// Shared types and defaults for the instruction fetch slice.
//
// Contents:
//   word_t        - 32-bit machine word
//   RESET_PC      - default first fetch address after reset
//   INSTR_BYTES   - default PC increment per sequential fetch
//   fetch_entry_t - one buffered instruction: PC, word and, when the
//                   INSTR_FETCH_MISALIGN_CHK_EN macro is defined, a fault flag
package pako_pkg;

  typedef logic [31:0] word_t;

  localparam word_t       RESET_PC    = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    word_t pc;
    word_t instr;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    logic  fault;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush.
//
// Parameters:
//   T     - entry type
//   Depth - number of entries (power of two, >= 2)
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   flush_i       - empty the FIFO; wins over push_i and pop_i
//   push_i/data_i - write one entry (caller guarantees space)
//   pop_i         - drop the head entry (caller guarantees non-empty)
//   data_o        - head entry
//   count_o       - number of stored entries
module sync_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  T                data_i,
  input  logic            pop_i,
  output T                data_o,
  output logic [CntW-1:0] count_o
);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a memory with one-cycle registered read latency.
//
// Drives a byte address to the memory every cycle, remembers whether that address was a
// real request (inflight_q/inflight_pc_q), pairs the returned word with its PC, buffers it
// in a DEPTH-entry FIFO and offers it to decode over valid/ready. A redirect flushes the
// FIFO, discards the in-flight response and restarts fetch at redirect_pc_i.
//
// Optional feature (macro INSTR_FETCH_MISALIGN_CHK_EN): a redirect to an address with
// bits[1:0] != 0 enqueues a single faulting entry (instr 0, fault 1) and halts fetch
// until the next redirect. Adds output instr_fault_o.
//
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   fetch_addr_o             - address to instruction memory (sampled every posedge)
//   fetch_data_i             - memory read data for the previous cycle's address
//   redirect_i/redirect_pc_i - flush and restart at redirect_pc_i
//   instr_valid_o/ready_i    - handshake to decode
//   instr_o, instr_pc_o      - head instruction and its PC
//   instr_fault_o            - (optional) head entry is a misaligned-target fault
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = pako_pkg::RESET_PC,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned INSTR_BYTES = pako_pkg::INSTR_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] fetch_addr_o,
  input  logic [31:0] fetch_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  output logic        instr_fault_o,
`endif
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);
  import pako_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;

  word_t           pc_q, pc_d;
  logic            inflight_q, inflight_d;
  word_t           inflight_pc_q, inflight_pc_d;
  logic            issue, push, pop;
  logic [CntW-1:0] count;
  logic [OccW-1:0] occupancy, limit;
  fetch_entry_t    push_entry, head_entry;

`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  // fault_pend_q marks the in-flight slot as the fault marker rather than a memory read.
  logic fault_pend_q, fault_pend_d;
  logic halt_q, halt_d;
  logic misaligned;
  assign misaligned = redirect_pc_i[1:0] != 2'b00;
`endif

  assign fetch_addr_o  = redirect_i ? redirect_pc_i : pc_q;
  assign instr_valid_o = count != '0;
  // A pop in the redirect cycle is not taken: the entry is flushed anyway.
  assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;
  assign push          = inflight_q & ~redirect_i;

  // A pop this cycle frees one slot, so compare against DEPTH + pop.
  assign occupancy = OccW'(count) + OccW'(inflight_q);
  assign limit     = OccW'(DEPTH) + OccW'(pop);

  always_comb begin
    issue = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    halt_d       = halt_q;
    fault_pend_d = 1'b0;
`endif
    if (redirect_i) begin
      issue = 1'b1;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
      halt_d       = misaligned;
      fault_pend_d = misaligned;
`endif
    end else begin
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
      issue = ~halt_q & (occupancy < limit);
`else
      issue = occupancy < limit;
`endif
    end
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_addr_o : inflight_pc_q;
    pc_d          = issue ? fetch_addr_o + word_t'(INSTR_BYTES) : pc_q;
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = inflight_pc_q;
    push_entry.instr = fetch_data_i;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    if (fault_pend_q) push_entry.instr = '0;
    push_entry.fault = fault_pend_q;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
      fault_pend_q  <= 1'b0;
      halt_q        <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
      fault_pend_q  <= fault_pend_d;
      halt_q        <= halt_d;
`endif
    end
  end

  sync_fifo #(
    .T     (fetch_entry_t),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (count)
  );

  // Empty FIFO presents zeros rather than stale storage.
  assign instr_o    = instr_valid_o ? head_entry.instr : '0;
  assign instr_pc_o = instr_valid_o ? head_entry.pc    : '0;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  assign instr_fault_o = instr_valid_o & head_entry.fault;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] W0     = 32'h0050_0093;
  localparam logic [31:0] W1     = 32'h0010_0113;
  localparam int unsigned SIZE_B = 1024;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] fetch_addr_o;
  logic [31:0] fetch_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  logic        instr_fault_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  instr_fetch dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_addr_o  (fetch_addr_o),
    .fetch_data_i  (fetch_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    .instr_fault_o (instr_fault_o),
`endif
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  // Memory contents: two fixed words at 0/4, address-tagged words elsewhere, 0 out of range.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= SIZE_B)      return 32'h0;
    if (a[31:2] == 30'd0) return W0;
    if (a[31:2] == 30'd1) return W1;
    return 32'hA000_0000 | {a[31:2], 2'b00};
  endfunction

  // One-cycle registered read port.
  always @(posedge clk_i) fetch_data_i <= mem_word(fetch_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Redirect for one cycle, then advance to two cycles after the redirect.
  task automatic redirect_to(input logic [31:0] a);
    redirect_i    = 1'b1;
    redirect_pc_i = a;
    instr_ready_i = 1'b1;
    #1;
    chk("redir_addr", fetch_addr_o, a);
    cyc();
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    cyc();
    #1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] addr);
    vec_t r;
    r.ready = rdy; r.redir = rd; r.rpc = rpc;
    r.exp_valid = v; r.exp_pc = pc; r.exp_instr = ins; r.exp_addr = addr;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni        = 1'b0;
    instr_ready_i = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;

    // Row i: inputs in cycle i after reset release, outputs expected in that cycle.
    vecs[0]  = mk(1, 0, 0,     0, 0,     0,                 32'h0);
    vecs[1]  = mk(1, 0, 0,     0, 0,     0,                 32'h4);
    vecs[2]  = mk(0, 0, 0,     1, 0,     W0,                32'h8);
    vecs[3]  = mk(0, 0, 0,     1, 0,     W0,                32'h8);
    vecs[4]  = mk(0, 0, 0,     1, 0,     W0,                32'h8);
    vecs[5]  = mk(0, 0, 0,     1, 0,     W0,                32'h8);
    vecs[6]  = mk(0, 0, 0,     1, 0,     W0,                32'h8);
    vecs[7]  = mk(0, 0, 0,     1, 0,     W0,                32'h8);
    vecs[8]  = mk(1, 0, 0,     1, 0,     W0,                32'h8);
    vecs[9]  = mk(1, 0, 0,     1, 32'h4, W1,                32'hC);
    vecs[10] = mk(0, 0, 0,     1, 32'h8, 32'hA000_0008,     32'h10);
    vecs[11] = mk(0, 0, 0,     1, 32'h8, 32'hA000_0008,     32'h10);
    vecs[12] = mk(1, 1, 32'h40, 1, 32'h8, 32'hA000_0008,    32'h40);
    vecs[13] = mk(1, 0, 0,     0, 0,     0,                 32'h44);
    vecs[14] = mk(1, 0, 0,     1, 32'h40, 32'hA000_0040,    32'h48);
    vecs[15] = mk(1, 0, 0,     1, 32'h44, 32'hA000_0044,    32'h4C);
    vecs[16] = mk(1, 1, 32'h10, 1, 32'h48, 32'hA000_0048,   32'h10);
    vecs[17] = mk(1, 1, 32'h80, 0, 0,     0,                32'h80);
    vecs[18] = mk(1, 0, 0,     0, 0,     0,                 32'h84);
    vecs[19] = mk(1, 0, 0,     1, 32'h80, 32'hA000_0080,    32'h88);
    vecs[20] = mk(1, 0, 0,     1, 32'h84, 32'hA000_0084,    32'h8C);

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk("rst_addr", fetch_addr_o, 32'h0);
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    chk("rst_fault", {31'b0, instr_fault_o}, 32'h0);
`endif

    rst_ni = 1'b1;
    for (int i = 0; i < NV; i++) begin
      instr_ready_i = vecs[i].ready;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      #1;
      chk($sformatf("c%0d_valid", i), {31'b0, instr_valid_o}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("c%0d_pc", i), instr_pc_o, vecs[i].exp_pc);
      chk($sformatf("c%0d_instr", i), instr_o, vecs[i].exp_instr);
      chk($sformatf("c%0d_addr", i), fetch_addr_o, vecs[i].exp_addr);
      cyc();
    end
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b1;

    // Crossing the end of memory: last real word, then 0 passed through as valid.
    redirect_to(32'h0000_03FC);
    chk("edge_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("edge_pc", instr_pc_o, 32'h0000_03FC);
    chk("edge_instr", instr_o, 32'hA000_03FC);
    cyc();
    chk("oor_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("oor_pc", instr_pc_o, 32'h0000_0400);
    chk("oor_instr", instr_o, 32'h0);

    // PC wrap from the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    chk("wrap_pc0", instr_pc_o, 32'hFFFF_FFFC);
    chk("wrap_instr0", instr_o, 32'h0);
    chk("wrap_addr", fetch_addr_o, 32'h4);
    cyc();
    chk("wrap_pc1", instr_pc_o, 32'h0);
    chk("wrap_instr1", instr_o, W0);

`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    redirect_to(32'h0000_0042);
    chk("mis_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("mis_pc", instr_pc_o, 32'h42);
    chk("mis_instr", instr_o, 32'h0);
    chk("mis_fault", {31'b0, instr_fault_o}, 32'h1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("mis_halt%0d", k), {31'b0, instr_valid_o}, 32'h0);
    end
    redirect_to(32'h0000_0044);
    chk("mis_rec_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("mis_rec_pc", instr_pc_o, 32'h44);
    chk("mis_rec_instr", instr_o, 32'hA000_0044);
    chk("mis_rec_fault", {31'b0, instr_fault_o}, 32'h0);
    cyc();
    chk("mis_rec_pc2", instr_pc_o, 32'h48);
`else
    redirect_to(32'h0000_0042);
    chk("mis_pc", instr_pc_o, 32'h42);
    chk("mis_instr", instr_o, 32'hA000_0040);
    cyc();
    chk("mis_pc2", instr_pc_o, 32'h46);
    chk("mis_instr2", instr_o, 32'hA000_0044);
`endif

    // Reset asserted mid-stream takes effect without a clock edge.
    rst_ni = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("mrst_pc", instr_pc_o, 32'h0);
    chk("mrst_instr", instr_o, 32'h0);
    chk("mrst_addr", fetch_addr_o, 32'h0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("mrst_c1_valid", {31'b0, instr_valid_o}, 32'h0);
    cyc();
    chk("mrst_c2_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("mrst_c2_pc", instr_pc_o, 32'h0);
    chk("mrst_c2_instr", instr_o, W0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
